// File: rtl/alu_issue_ctrl_if.sv
// Issue-stage bundle: upstream decode handshake, downstream
// issue payload handshake and the multi-cycle unit start/done pair.
interface alu_issue_ctrl_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rv1;
  logic [XLEN-1:0] rv2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] i1;
  logic [XLEN-1:0] i2;
  logic [OPW-1:0]  opcode;
  logic            illegal;
  logic            md_start;
  logic            md_done;

  modport master (
    output in_valid, instr, pc, imm, rv1, rv2,
    output out_ready, md_done,
    input  in_ready, out_valid, i1, i2,
    input  opcode, illegal, md_start
  );

  modport slave (
    input  in_valid, instr, pc, imm, rv1, rv2,
    input  out_ready, md_done,
    output in_ready, out_valid, i1, i2,
    output opcode, illegal, md_start
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue control: decodes RV32I/M operands and ALU opcode,
// holds the payload for downstream and sequences multi-cycle ops.
module alu_issue_ctrl #(
  parameter int XLEN       = 32,
  parameter int OPW        = 5,
  parameter int MULDIV_EN  = 1,
  parameter int MD_TIMEOUT = 64
) (
  input logic             clk,
  input logic             reset,
  alu_issue_ctrl_if.slave bus
);
  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [OPW-1:0] OPC_BAD = OPW'(15);

  typedef enum logic [1:0] {IDLE, HOLD, MD_BUSY} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [XLEN-1:0] i1_q, i1_d, i2_q, i2_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            ill_q, ill_d;
  logic            accept;

  logic [XLEN-1:0] dec_i1, dec_i2;
  logic [OPW-1:0]  dec_op;
  logic            dec_ill, dec_md;
  logic [2:0]      f3;
  logic            b30;
  logic            is_lui, is_auipc, is_jal, is_jalr;
  logic            is_br, is_ldst, is_op, is_opi;
  logic            is_m, is_mop, is_alu;
  logic            unused_bits;

  assign unused_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  assign f3       = bus.instr[14:12];
  assign is_lui   = bus.instr[6:0] == 7'b0110111;
  assign is_auipc = bus.instr[6:0] == 7'b0010111;
  assign is_jal   = bus.instr[6:0] == 7'b1101111;
  assign is_jalr  = bus.instr[6:0] == 7'b1100111;
  assign is_br    = bus.instr[6:0] == 7'b1100011;
  assign is_ldst  = (bus.instr[6:0] == 7'b0000011)
                 || (bus.instr[6:0] == 7'b0100011);
  assign is_op    = bus.instr[6:0] == 7'b0110011;
  assign is_opi   = bus.instr[6:0] == 7'b0010011;
  assign is_m     = bus.instr[31:25] == 7'b0000001;
  assign is_mop   = is_op && is_m;
  assign is_alu   = (is_op && !is_m) || is_opi;
  // OP-IMM only uses instr[30] for shifts; elsewhere it is immediate data
  assign b30      = bus.instr[30] && (is_op || f3 == 3'b101);

  always_comb begin
    dec_i1  = bus.rv1;
    dec_i2  = bus.rv2;
    dec_op  = OPC_BAD;
    dec_ill = 1'b1;
    dec_md  = 1'b0;
    unique case (1'b1)
      is_lui: begin
        dec_i1  = bus.imm;
        dec_i2  = '0;
        dec_op  = '0;
        dec_ill = 1'b0;
      end
      is_auipc: begin
        dec_i1  = bus.imm;
        dec_i2  = bus.pc;
        dec_op  = '0;
        dec_ill = 1'b0;
      end
      is_jal: begin
        dec_i1  = bus.pc;
        dec_i2  = bus.imm;
        dec_op  = '0;
        dec_ill = 1'b0;
      end
      is_jalr: begin
        dec_i2  = bus.imm;
        dec_op  = '0;
        dec_ill = 1'b0;
      end
      is_ldst: begin
        dec_i1  = bus.imm;
        dec_i2  = bus.rv1;
        dec_op  = '0;
        dec_ill = 1'b0;
      end
      is_br: begin
        dec_ill = 1'b0;
        case (f3)
          3'b000:  dec_op = OPW'(12);
          3'b001:  dec_op = OPW'(13);
          3'b100:  dec_op = OPW'(3);
          3'b101:  dec_op = OPW'(11);
          3'b110:  dec_op = OPW'(4);
          3'b111:  dec_op = OPW'(10);
          default: dec_ill = 1'b1;
        endcase
      end
      is_mop: begin
        if (MULDIV_EN != 0) begin
          dec_op  = OPW'({2'b10, f3});
          dec_ill = 1'b0;
          dec_md  = 1'b1;
        end
      end
      is_alu: begin
        if (is_opi) dec_i2 = bus.imm;
        dec_ill = 1'b0;
        case ({b30, f3})
          4'b0000: dec_op = OPW'(0);
          4'b1000: dec_op = OPW'(1);
          4'b0001: dec_op = OPW'(2);
          4'b0010: dec_op = OPW'(3);
          4'b0011: dec_op = OPW'(4);
          4'b0100: dec_op = OPW'(5);
          4'b0101: dec_op = OPW'(6);
          4'b1101: dec_op = OPW'(7);
          4'b0111: dec_op = OPW'(8);
          4'b0110: dec_op = OPW'(9);
          default: dec_ill = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = (state == IDLE)
                      || (state == HOLD && bus.out_ready);
  assign bus.out_valid = state == HOLD;
  assign bus.md_start  = (state == MD_BUSY) && (cnt == '0);
  assign bus.i1        = i1_q;
  assign bus.i2        = i2_q;
  assign bus.opcode    = op_q;
  assign bus.illegal   = ill_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    i1_d    = i1_q;
    i2_d    = i2_q;
    op_d    = op_q;
    ill_d   = ill_q;
    unique case (state)
      IDLE, HOLD: begin
        if (accept) begin
          state_d = dec_md ? MD_BUSY : HOLD;
          cnt_d   = '0;
          i1_d    = dec_i1;
          i2_d    = dec_i2;
          op_d    = dec_op;
          ill_d   = dec_ill;
        end else if (state == HOLD && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      MD_BUSY: begin
        if (bus.md_done) begin
          state_d = HOLD;
          cnt_d   = '0;
          ill_d   = 1'b0;
        end else if (cnt == CW'(MD_TIMEOUT - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          op_d    = OPC_BAD;
          ill_d   = 1'b1;
        end else begin
          cnt_d   = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      i1_q  <= '0;
      i2_q  <= '0;
      op_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      op_q  <= op_d;
      ill_q <= ill_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: decode table, streaming,
// back-pressure, multi-cycle done/timeout and reset mid-operation.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.XLEN(32), .OPW(5)) bus ();
  alu_issue_ctrl_if #(.XLEN(32), .OPW(5)) bus2 ();

  alu_issue_ctrl #(
    .XLEN(32), .OPW(5), .MULDIV_EN(1), .MD_TIMEOUT(8)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  alu_issue_ctrl #(
    .XLEN(32), .OPW(5), .MULDIV_EN(0), .MD_TIMEOUT(8)
  ) u_nomd (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam int NV = 13;
  logic [31:0] v_ins [NV] = '{
    32'h000000B7, 32'h00000097, 32'h0000006F, 32'h00008067,
    32'h0000A083, 32'h0020A023, 32'h4010D093, 32'h0020B1B3,
    32'h0020D063, 32'h00209063, 32'h0020A063, 32'h0000007F,
    32'h0020E1B3};
  logic [31:0] v_i1 [NV] = '{
    32'h20, 32'h20, 32'h1000, 32'h7, 32'h20, 32'h20, 32'h7,
    32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7};
  logic [31:0] v_i2 [NV] = '{
    32'h0, 32'h1000, 32'h20, 32'h20, 32'h7, 32'h7, 32'h20,
    32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9};
  logic [4:0] v_op [NV] = '{
    5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7,
    5'd4, 5'd11, 5'd13, 5'd15, 5'd15, 5'd9};
  logic v_ill [NV] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.pc        = '0;
    bus.imm       = '0;
    bus.rv1       = '0;
    bus.rv2       = '0;
    bus.out_ready = 1'b1;
    bus.md_done   = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.instr     = '0;
    bus2.pc        = '0;
    bus2.imm       = '0;
    bus2.rv1       = '0;
    bus2.rv2       = '0;
    bus2.out_ready = 1'b1;
    bus2.md_done   = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_md_start", bus.md_start, 0);
    chk("rst_i1", bus.i1, 0);
    chk("rst_opcode", bus.opcode, 0);
    chk("rst_illegal", bus.illegal, 0);
    reset = 1'b0;

    // ADDI x1, x0, 5 with rv1=7
    bus.instr    = 32'h00500093;
    bus.rv1      = 32'd7;
    bus.imm      = 32'd5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_i1", bus.i1, 7);
    chk("addi_i2", bus.i2, 5);
    chk("addi_op", bus.opcode, 0);
    chk("addi_ill", bus.illegal, 0);
    tick();
    chk("addi_retire", bus.out_valid, 0);

    // SUB then AND streamed
    bus.instr    = 32'h402081B3;
    bus.rv1      = 32'd10;
    bus.rv2      = 32'd3;
    bus.in_valid = 1'b1;
    #1;
    chk("sub_in_ready", bus.in_ready, 1);
    tick();
    bus.instr = 32'h0020F1B3;
    #1;
    chk("and_in_ready", bus.in_ready, 1);
    chk("sub_valid", bus.out_valid, 1);
    chk("sub_op", bus.opcode, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("and_valid", bus.out_valid, 1);
    chk("and_op", bus.opcode, 8);
    tick();
    chk("and_retire", bus.out_valid, 0);

    // BLTU under 3 cycles of back-pressure, ADDI waiting behind it
    bus.instr     = 32'h0020E063;
    bus.rv1       = 32'h11;
    bus.rv2       = 32'h22;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.instr = 32'h00500093;
    bus.rv1   = 32'd7;
    bus.imm   = 32'd5;
    for (int k = 0; k < 3; k++) begin
      chk("bltu_valid", bus.out_valid, 1);
      chk("bltu_op", bus.opcode, 4);
      chk("bltu_i1", bus.i1, 32'h11);
      chk("bltu_i2", bus.i2, 32'h22);
      chk("bltu_in_ready", bus.in_ready, 0);
      if (k < 2) tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bltu_release_rdy", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_valid", bus.out_valid, 1);
    chk("b2b_op", bus.opcode, 0);
    chk("b2b_i1", bus.i1, 7);
    chk("b2b_i2", bus.i2, 5);
    tick();
    chk("b2b_retire", bus.out_valid, 0);

    // decode table, streamed back-to-back
    bus.pc  = 32'h1000;
    bus.imm = 32'h20;
    bus.rv1 = 32'h7;
    bus.rv2 = 32'h9;
    bus.in_valid = 1'b1;
    for (int v = 0; v < NV; v++) begin
      bus.instr = v_ins[v];
      tick();
      chk($sformatf("dec%0d_i1", v), bus.i1, v_i1[v]);
      chk($sformatf("dec%0d_i2", v), bus.i2, v_i2[v]);
      chk($sformatf("dec%0d_op", v), bus.opcode, v_op[v]);
      chk($sformatf("dec%0d_ill", v), bus.illegal, v_ill[v]);
    end
    bus.in_valid = 1'b0;
    tick();

    // md_done in IDLE is ignored
    bus.md_done = 1'b1;
    tick();
    bus.md_done = 1'b0;
    chk("idle_done_valid", bus.out_valid, 0);
    chk("idle_done_rdy", bus.in_ready, 1);

    // DIV completing in its 5th busy cycle
    bus.instr    = 32'h0220C1B3;
    bus.rv1      = 32'd100;
    bus.rv2      = 32'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("div_md_start0", bus.md_start, 1);
    chk("div_valid0", bus.out_valid, 0);
    chk("div_in_ready", bus.in_ready, 0);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("div_md_start", bus.md_start, 0);
      chk("div_valid", bus.out_valid, 0);
    end
    bus.md_done = 1'b1;
    tick();
    bus.md_done = 1'b0;
    chk("div_done_valid", bus.out_valid, 1);
    chk("div_op", bus.opcode, 20);
    chk("div_ill", bus.illegal, 0);
    chk("div_i1", bus.i1, 100);
    chk("div_i2", bus.i2, 7);
    tick();
    chk("div_retire", bus.out_valid, 0);

    // MUL never completes: timeout after 8 busy cycles
    bus.instr    = 32'h022081B3;
    bus.in_valid = 1'b1;
    bus2.instr    = 32'h022081B3;
    bus2.rv1      = 32'd3;
    bus2.rv2      = 32'd4;
    bus2.in_valid = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus2.in_valid = 1'b0;
    chk("nomd_valid", bus2.out_valid, 1);
    chk("nomd_op", bus2.opcode, 15);
    chk("nomd_ill", bus2.illegal, 1);
    chk("nomd_md_start", bus2.md_start, 0);
    chk("mul_md_start", bus.md_start, 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("mul_busy_valid", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;
    tick();
    chk("mul_to_valid", bus.out_valid, 1);
    chk("mul_to_op", bus.opcode, 15);
    chk("mul_to_ill", bus.illegal, 1);
    bus.md_done = 1'b1;
    tick();
    bus.md_done = 1'b0;
    chk("mul_late_done_op", bus.opcode, 15);
    chk("mul_late_done_ill", bus.illegal, 1);
    chk("mul_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("mul_retire", bus.out_valid, 0);

    // reset on second MD_BUSY cycle wins over md_done
    bus.instr    = 32'h0220C1B3;
    bus.rv1      = 32'd100;
    bus.rv2      = 32'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rmd_md_start", bus.md_start, 0);
    chk("rmd_busy_valid", bus.out_valid, 0);
    reset       = 1'b1;
    bus.md_done = 1'b1;
    tick();
    reset       = 1'b0;
    bus.md_done = 1'b0;
    chk("rmd_valid", bus.out_valid, 0);
    chk("rmd_md_start2", bus.md_start, 0);
    chk("rmd_i1", bus.i1, 0);
    chk("rmd_i2", bus.i2, 0);
    chk("rmd_op", bus.opcode, 0);
    chk("rmd_ill", bus.illegal, 0);
    chk("rmd_in_ready", bus.in_ready, 1);
    bus.md_done = 1'b1;
    tick();
    bus.md_done = 1'b0;
    chk("rmd_late_valid", bus.out_valid, 0);
    chk("rmd_late_rdy", bus.in_ready, 1);
    chk("rmd_late_op", bus.opcode, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
